// File: rtl/pipeline_sram_arbiter_if.sv
// Request, upload and SRAM-pin bundle for the foreground SRAM arbiter.
// slave: the arbiter; master: requesters plus the SRAM device.
interface pipeline_sram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  ctrl_fg_freeze;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ack;
    logic                  up_start;
    logic [ADDR_WIDTH-1:0] up_base_addr;
    logic [ADDR_WIDTH-1:0] up_word_count;
    logic [7:0]            up_byte;
    logic                  up_byte_valid;
    logic                  up_busy;
    logic                  up_done;
    logic                  up_overflow;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic                  sram_we_n;
    logic                  sram_oe_n;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  ctrl_fg_freeze, rd_req, rd_addr, wr_req, wr_addr, wr_data,
               up_start, up_base_addr, up_word_count, up_byte, up_byte_valid, sram_rdata,
        output rd_valid, rd_data, wr_ack, up_busy, up_done, up_overflow,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n
    );

    modport master (
        output ctrl_fg_freeze, rd_req, rd_addr, wr_req, wr_addr, wr_data,
               up_start, up_base_addr, up_word_count, up_byte, up_byte_valid, sram_rdata,
        input  rd_valid, rd_data, wr_ack, up_busy, up_done, up_overflow,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/pipeline_sram_arbiter.sv
// Single-port foreground SRAM arbiter: pipeline read > capture write > SPI upload,
// one registered SRAM operation per clock. DATA_WIDTH must be 16 (two bytes per word).
module pipeline_sram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_sram_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        UP_IDLE  = 2'd0,
        UP_RECV  = 2'd1,
        UP_DRAIN = 2'd2
    } up_state_e;

    up_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic                  have_hi_q, have_hi_d;
    logic [7:0]            hi_byte_q, hi_byte_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [PTR_W-1:0]      fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_ack_q, wr_ack_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic                  sram_we_n_q, sram_we_n_d;
    logic                  sram_oe_n_q, sram_oe_n_d;

    logic                  rd_grant, wr_slot, wr_grant, up_grant;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] push_data;

    // Arbitration, read pipeline, byte packer, FIFO and upload FSM next state
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        remaining_d   = remaining_q;
        have_hi_d     = have_hi_q;
        hi_byte_d     = hi_byte_q;
        overflow_d    = overflow_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        rd_pipe_d     = rd_pipe_q;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        wr_ack_d      = 1'b0;
        sram_addr_d   = sram_addr_q;
        sram_wdata_d  = sram_wdata_q;
        sram_we_n_d   = 1'b1;
        sram_oe_n_d   = 1'b1;
        push          = 1'b0;
        pop           = 1'b0;
        push_data     = '0;

        fifo_empty = (fifo_cnt_q == '0);
        fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
        rd_grant   = bus.rd_req;
        wr_slot    = !bus.rd_req && bus.wr_req;
        wr_grant   = wr_slot && !bus.ctrl_fg_freeze;
        up_grant   = !rd_grant && !wr_grant && !fifo_empty;

        if (rd_grant) begin
            sram_addr_d = bus.rd_addr;
            sram_oe_n_d = 1'b0;
        end else if (wr_grant) begin
            sram_addr_d  = bus.wr_addr;
            sram_wdata_d = bus.wr_data;
            sram_we_n_d  = 1'b0;
        end else if (up_grant) begin
            sram_addr_d  = ptr_q;
            sram_wdata_d = fifo_mem_q[fifo_rd_ptr_q];
            sram_we_n_d  = 1'b0;
            ptr_d        = ptr_q + ADDR_WIDTH'(1);
            pop          = 1'b1;
        end
        // A frozen capture is still acknowledged so the capture side never stalls
        wr_ack_d = wr_slot;

        rd_pipe_d[0] = rd_grant;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
        if (rd_pipe_q[RD_LATENCY-1]) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.sram_rdata;
        end

        unique case (state_q)
            UP_IDLE: begin
                if (bus.up_start) begin
                    ptr_d       = bus.up_base_addr;
                    remaining_d = bus.up_word_count;
                    overflow_d  = 1'b0;
                    have_hi_d   = 1'b0;
                    hi_byte_d   = 8'h00;
                    if (bus.up_word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = UP_RECV;
                        busy_d  = 1'b1;
                    end
                end
            end
            UP_RECV: begin
                if (bus.up_byte_valid) begin
                    if (!have_hi_q) begin
                        hi_byte_d = bus.up_byte;
                        have_hi_d = 1'b1;
                    end else begin
                        have_hi_d   = 1'b0;
                        remaining_d = remaining_q - ADDR_WIDTH'(1);
                        // A simultaneous pop frees a slot, so a full FIFO still accepts
                        if (!fifo_full || pop) begin
                            push      = 1'b1;
                            push_data = DATA_WIDTH'({hi_byte_q, bus.up_byte});
                        end else begin
                            overflow_d = 1'b1;
                        end
                        if (remaining_q == ADDR_WIDTH'(1)) begin
                            state_d = UP_DRAIN;
                        end
                    end
                end
            end
            UP_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = UP_IDLE;
                end
            end
            default: state_d = UP_IDLE;
        endcase

        if (push) fifo_wr_ptr_d = fifo_wr_ptr_q + PTR_W'(1);
        if (pop)  fifo_rd_ptr_d = fifo_rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= UP_IDLE;
            ptr_q         <= '0;
            remaining_q   <= '0;
            have_hi_q     <= 1'b0;
            hi_byte_q     <= 8'h00;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
            rd_pipe_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            wr_ack_q      <= 1'b0;
            sram_addr_q   <= '0;
            sram_wdata_q  <= '0;
            sram_we_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            remaining_q   <= remaining_d;
            have_hi_q     <= have_hi_d;
            hi_byte_q     <= hi_byte_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            rd_pipe_q     <= rd_pipe_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            wr_ack_q      <= wr_ack_d;
            sram_addr_q   <= sram_addr_d;
            sram_wdata_q  <= sram_wdata_d;
            sram_we_n_q   <= sram_we_n_d;
            sram_oe_n_q   <= sram_oe_n_d;
        end
    end

    // Storage needs no reset: the cleared pointers make stale entries unreachable
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem_q[fifo_wr_ptr_q] <= push_data;
        end
    end

    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.up_busy     = busy_q;
    assign bus.up_done     = done_q;
    assign bus.up_overflow = overflow_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_wdata  = sram_wdata_q;
    assign bus.sram_we_n   = sram_we_n_q;
    assign bus.sram_oe_n   = sram_oe_n_q;

endmodule

// File: tb/tb_pipeline_sram_arbiter.sv
// Directed bench for pipeline_sram_arbiter with a two-cycle synchronous SRAM model.
module tb_pipeline_sram_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   rdv_cnt;
    logic [18:0] wlog_addr [$];
    logic [15:0] wlog_data [$];
    logic [15:0] sram_mem [0:(1<<19)-1];
    bit          sram_wr  [0:(1<<19)-1];

    pipeline_sram_arbiter_if #(.ADDR_WIDTH(19), .DATA_WIDTH(16)) bus ();

    pipeline_sram_arbiter #(
        .ADDR_WIDTH(19), .DATA_WIDTH(16), .FIFO_DEPTH(4), .RD_LATENCY(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: address registered by the DUT, data returned one edge later
    always @(posedge clk) begin
        if (!bus.sram_oe_n) bus.sram_rdata <= sram_wr[bus.sram_addr] ? sram_mem[bus.sram_addr] : 16'hDEAD;
        if (!bus.sram_we_n) begin
            sram_mem[bus.sram_addr] <= bus.sram_wdata;
            sram_wr[bus.sram_addr]  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.rd_valid) rdv_cnt <= rdv_cnt + 1;
        if (!bus.sram_we_n) begin
            wlog_addr.push_back(bus.sram_addr);
            wlog_data.push_back(bus.sram_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_upload(input logic [18:0] base, input logic [18:0] count);
        bus.up_base_addr  = base;
        bus.up_word_count = count;
        bus.up_start      = 1'b1;
        tick();
        bus.up_start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.up_byte       = b;
        bus.up_byte_valid = 1'b1;
        tick();
        bus.up_byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (bus.up_done) pulses++;
        end
    endtask

    task automatic test_reset();
        int v0;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 19'h00005;
        v0 = rdv_cnt;
        tick();
        checks++; if (bus.sram_oe_n !== 1'b0 || bus.sram_addr !== 19'h00005) begin errors++;
            $display("FAIL reset_read_issue: oe_n=%b addr=%h, expected oe_n=0 addr=00005", bus.sram_oe_n, bus.sram_addr); end
        bus.rd_req = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.sram_we_n !== 1'b1 || bus.sram_oe_n !== 1'b1) begin errors++;
            $display("FAIL reset_strobes: we_n=%b oe_n=%b, expected 1 1", bus.sram_we_n, bus.sram_oe_n); end
        checks++; if (bus.up_busy !== 1'b0 || bus.sram_addr !== 19'h0 || bus.wr_ack !== 1'b0) begin errors++;
            $display("FAIL reset_outputs: busy=%b addr=%h ack=%b, expected 0 0 0", bus.up_busy, bus.sram_addr, bus.wr_ack); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (rdv_cnt !== v0) begin errors++;
            $display("FAIL reset_no_rd_valid: got %0d valid pulses, expected 0", rdv_cnt - v0); end
    endtask

    task automatic test_rd_wr_priority();
        bus.rd_req  = 1'b1;
        bus.rd_addr = 19'h00020;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 19'h00020;
        bus.wr_data = 16'h1234;
        tick();
        checks++; if (bus.sram_oe_n !== 1'b0 || bus.sram_we_n !== 1'b1 || bus.wr_ack !== 1'b0) begin errors++;
            $display("FAIL prio_read_first: oe_n=%b we_n=%b ack=%b, expected 0 1 0", bus.sram_oe_n, bus.sram_we_n, bus.wr_ack); end
        bus.rd_req = 1'b0;
        tick();
        checks++; if (bus.wr_ack !== 1'b1 || bus.sram_we_n !== 1'b0 || bus.sram_wdata !== 16'h1234) begin errors++;
            $display("FAIL prio_write_next: ack=%b we_n=%b wdata=%h, expected 1 0 1234", bus.wr_ack, bus.sram_we_n, bus.sram_wdata); end
        bus.wr_req = 1'b0;
        tick();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hDEAD || bus.wr_ack !== 1'b0) begin errors++;
            $display("FAIL prio_old_data: valid=%b data=%h ack=%b, expected 1 dead 0", bus.rd_valid, bus.rd_data, bus.wr_ack); end
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++;
            $display("FAIL latency_early1: valid=%b, expected 0", bus.rd_valid); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++;
            $display("FAIL latency_early2: valid=%b, expected 0", bus.rd_valid); end
        tick();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h1234) begin errors++;
            $display("FAIL readback: valid=%b data=%h, expected 1 1234", bus.rd_valid, bus.rd_data); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = 19'(19'h00030 + i);
            bus.wr_data = 16'((i + 1) * 16'h1111);
            tick();
            checks++; if (bus.wr_ack !== 1'b1) begin errors++;
                $display("FAIL b2b_wr_ack%0d: got %b expected 1", i, bus.wr_ack); end
            bus.wr_req = 1'b0;
            tick();
        end
        bus.rd_req = 1'b1; bus.rd_addr = 19'h00030; tick();
        bus.rd_addr = 19'h00031; tick();
        bus.rd_addr = 19'h00032; tick();
        bus.rd_req = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h1111) begin errors++;
            $display("FAIL b2b_rd0: valid=%b data=%h, expected 1 1111", bus.rd_valid, bus.rd_data); end
        tick();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h2222) begin errors++;
            $display("FAIL b2b_rd1: valid=%b data=%h, expected 1 2222", bus.rd_valid, bus.rd_data); end
        tick();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h3333) begin errors++;
            $display("FAIL b2b_rd2: valid=%b data=%h, expected 1 3333", bus.rd_valid, bus.rd_data); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_rd_end: valid=%b, expected 0", bus.rd_valid); end
    endtask

    task automatic test_freeze();
        int w0;
        w0 = wlog_addr.size();
        bus.ctrl_fg_freeze = 1'b1;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 19'h00040;
        bus.wr_data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.wr_ack !== 1'b1 || bus.sram_we_n !== 1'b1) begin errors++;
                $display("FAIL freeze_cycle%0d: ack=%b we_n=%b, expected 1 1", i, bus.wr_ack, bus.sram_we_n); end
        end
        bus.wr_req = 1'b0;
        tick();
        bus.ctrl_fg_freeze = 1'b0;
        checks++; if (bus.wr_ack !== 1'b0 || wlog_addr.size() != w0) begin errors++;
            $display("FAIL freeze_after: ack=%b writes=%0d, expected 0 0", bus.wr_ack, wlog_addr.size() - w0); end
    endtask

    task automatic test_upload();
        int w0;
        int pulses;
        w0 = wlog_addr.size();
        start_upload(19'h00100, 19'd2);
        checks++; if (bus.up_busy !== 1'b1) begin errors++;
            $display("FAIL upload_busy: got %b expected 1", bus.up_busy); end
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF); send_byte(8'h01);
        wait_done(20, pulses);
        checks++; if (pulses != 1 || bus.up_busy !== 1'b0 || bus.up_overflow !== 1'b0) begin errors++;
            $display("FAIL upload_done: pulses=%0d busy=%b ovf=%b, expected 1 0 0", pulses, bus.up_busy, bus.up_overflow); end
        checks++; if (wlog_addr.size() != w0 + 2) begin errors++;
            $display("FAIL upload_nwrites: got %0d expected 2", wlog_addr.size() - w0); end
        else begin
            checks++; if (wlog_addr[w0] !== 19'h00100 || wlog_data[w0] !== 16'hABCD) begin errors++;
                $display("FAIL upload_w0: %h@%h, expected abcd@00100", wlog_data[w0], wlog_addr[w0]); end
            checks++; if (wlog_addr[w0+1] !== 19'h00101 || wlog_data[w0+1] !== 16'hEF01) begin errors++;
                $display("FAIL upload_w1: %h@%h, expected ef01@00101", wlog_data[w0+1], wlog_addr[w0+1]); end
        end
    endtask

    task automatic test_overflow();
        int w0;
        int pulses;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 19'h00000;
        w0 = wlog_addr.size();
        start_upload(19'h00200, 19'd10);
        for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
        checks++; if (bus.up_overflow !== 1'b1 || bus.up_busy !== 1'b1 || wlog_addr.size() != w0) begin errors++;
            $display("FAIL ovf_starved: ovf=%b busy=%b writes=%0d, expected 1 1 0", bus.up_overflow, bus.up_busy, wlog_addr.size() - w0); end
        bus.rd_req = 1'b0;
        wait_done(20, pulses);
        checks++; if (pulses != 1 || bus.up_overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_done: pulses=%0d ovf=%b, expected 1 1", pulses, bus.up_overflow); end
        checks++; if (wlog_addr.size() != w0 + 4) begin errors++;
            $display("FAIL ovf_nwrites: got %0d expected 4", wlog_addr.size() - w0); end
        else begin
            checks++; if (wlog_addr[w0] !== 19'h00200 || wlog_data[w0] !== 16'h1011 ||
                          wlog_addr[w0+3] !== 19'h00203 || wlog_data[w0+3] !== 16'h1617) begin errors++;
                $display("FAIL ovf_words: first %h@%h last %h@%h, expected 1011@00200 1617@00203",
                         wlog_data[w0], wlog_addr[w0], wlog_data[w0+3], wlog_addr[w0+3]); end
        end
    endtask

    task automatic test_wrap();
        int w0;
        int pulses;
        w0 = wlog_addr.size();
        start_upload(19'h7FFFF, 19'd2);
        checks++; if (bus.up_overflow !== 1'b0) begin errors++;
            $display("FAIL wrap_ovf_clear: got %b expected 0", bus.up_overflow); end
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        wait_done(20, pulses);
        checks++; if (pulses != 1 || wlog_addr.size() != w0 + 2) begin errors++;
            $display("FAIL wrap_done: pulses=%0d writes=%0d, expected 1 2", pulses, wlog_addr.size() - w0); end
        else begin
            checks++; if (wlog_addr[w0] !== 19'h7FFFF || wlog_addr[w0+1] !== 19'h00000 || wlog_data[w0+1] !== 16'h5678) begin errors++;
                $display("FAIL wrap_addr: %h then %h@%h, expected 7ffff then 5678@00000",
                         wlog_addr[w0], wlog_data[w0+1], wlog_addr[w0+1]); end
        end
    endtask

    task automatic test_count_zero();
        int w0;
        w0 = wlog_addr.size();
        start_upload(19'h00300, 19'd0);
        checks++; if (bus.up_done !== 1'b1 || bus.up_busy !== 1'b0) begin errors++;
            $display("FAIL zero_done: done=%b busy=%b, expected 1 0", bus.up_done, bus.up_busy); end
        tick();
        checks++; if (bus.up_done !== 1'b0) begin errors++;
            $display("FAIL zero_pulse_len: done=%b expected 0", bus.up_done); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (wlog_addr.size() != w0) begin errors++;
            $display("FAIL zero_nowrite: got %0d writes expected 0", wlog_addr.size() - w0); end
    endtask

    task automatic test_start_busy();
        int w0;
        int pulses;
        w0 = wlog_addr.size();
        start_upload(19'h00400, 19'd1);
        start_upload(19'h00500, 19'd3);
        checks++; if (bus.up_busy !== 1'b1 || bus.up_done !== 1'b0) begin errors++;
            $display("FAIL busy_restart: busy=%b done=%b, expected 1 0", bus.up_busy, bus.up_done); end
        send_byte(8'h9A); send_byte(8'hBC);
        wait_done(20, pulses);
        checks++; if (pulses != 1 || wlog_addr.size() != w0 + 1) begin errors++;
            $display("FAIL busy_done: pulses=%0d writes=%0d, expected 1 1", pulses, wlog_addr.size() - w0); end
        else begin
            checks++; if (wlog_addr[w0] !== 19'h00400 || wlog_data[w0] !== 16'h9ABC) begin errors++;
                $display("FAIL busy_word: %h@%h, expected 9abc@00400", wlog_data[w0], wlog_addr[w0]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rdv_cnt = 0;
        rst_n = 1'b0;
        bus.ctrl_fg_freeze = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.up_start = 1'b0;
        bus.up_base_addr = '0;
        bus.up_word_count = '0;
        bus.up_byte = '0;
        bus.up_byte_valid = 1'b0;
        bus.sram_rdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_rd_wr_priority();
        test_back_to_back();
        test_freeze();
        test_upload();
        test_overflow();
        test_wrap();
        test_count_zero();
        test_start_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
